i2c_slave_regif_mc: RTL
=======================

Name: i2c_slave_regif_mc

Overview:
Parametrised I2C-slave register front end that sits between the byte-level I2C slave engine and CPLD register banks.
It decodes up to NUM_DEV 7-bit slave addresses, builds a 1- or 2-byte register pointer, and issues single-cycle write strobes.
It prefetches read data through a request/ack handshake with timeout, auto-increments the pointer with wrap-around, and keeps the pointer across repeated start so write-pointer-then-read transactions work.

Parameters:
NUM_DEV, 2, number of decoded slave addresses (1..4)
ADDR_BYTES, 2, register pointer bytes, MSB first (1 or 2); PW = 8*ADDR_BYTES
RD_TMO, 15, i_clk cycles to wait for i_rd_ack before substituting 8'hFF (1..255)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  engine START/repeated-START pulse, i_clk synchronous
i_stop  in  1  engine STOP pulse, i_clk synchronous
i_addr_vld  in  1  pulse, i_dev_addr/i_rw valid after address byte
i_dev_addr  in  7  received slave address
i_rw  in  1  1 = master read, 0 = master write
i_byte_vld  in  1  engine data-valid level; rising edge = one byte done
i_byte  in  8  received byte, stable while i_byte_vld high
i_dev_tbl  in  7*NUM_DEV  slave address table, entry k at [7k+6:7k]
i_dev_en  in  NUM_DEV  per-entry enable
o_hit  out  1  current transaction addressed to this block
o_dev_sel  out  2  index of matched entry
o_reg_addr  out  PW  register pointer
o_wr_en  out  1  one-cycle write strobe
o_wr_data  out  8  write data, valid with o_wr_en
o_rd_req  out  1  one-cycle read request for o_reg_addr
i_rd_data  in  8  read data, sampled on i_rd_ack
i_rd_ack  in  1  read data valid pulse
o_tx_byte  out  8  byte presented to the engine for the next read slot
o_rd_tmo  out  1  sticky: a read timed out; cleared by i_start
o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, o_reg_addr 0, FSM = IDLE. Reset mid-transfer aborts with no strobe.
- Byte edge: byte_pe = i_byte_vld & ~prev, one register stage, so byte_pe is 1 cycle after the rising edge.
- FSM states: IDLE, PTR, WDATA, RDATA, IGNORE.
- IDLE/any state + i_start: clear byte counter and o_rd_tmo, go to IDLE-wait-addr. o_reg_addr is kept.
- i_addr_vld: o_hit = 1 if any enabled entry equals i_dev_addr; the lowest index wins and sets o_dev_sel.
- On a miss, o_hit = 0 and go to IGNORE; all byte_pe are ignored until the next i_start or i_stop.
- On a hit with i_rw = 0, go to PTR. On a hit with i_rw = 1, go to RDATA and issue o_rd_req the next cycle.
- PTR: each byte_pe shifts i_byte into the pointer, MSB first. After ADDR_BYTES bytes, go to WDATA. No strobe in PTR.
- WDATA, on each byte_pe:
  - o_wr_en = 1 for one cycle, with o_wr_data = i_byte and o_reg_addr = current pointer.
  - The pointer increments on the cycle after the strobe.
- RDATA:
  - o_rd_req pulses once per pointer value, and the timeout counter starts.
  - On i_rd_ack, o_tx_byte = i_rd_data.
  - If RD_TMO cycles pass with no ack, o_tx_byte = 8'hFF and o_rd_tmo = 1.
  - Each byte_pe (byte shifted out): pointer++, then a new o_rd_req the next cycle.
  - A late ack after timeout is ignored.
- Wrap: the pointer at 2^PW-1 increments to 0, with no flag.
- i_stop: go to IDLE, o_hit = 0, pointer retained. A pending rd_req is abandoned.
- Simultaneous i_start and byte_pe: i_start wins, and the byte is dropped.
- i_stop and byte_pe in the same cycle: the byte is processed first, then IDLE.
- Repeated start with no stop: re-decode the address. Read-after-write starts at the pointer loaded in PTR.
- Latency: byte_vld rise to o_wr_en = 2 cycles. Read byte_pe to o_rd_req = 2 cycles.

Test Plan:
- Reset release -> o_reg_addr=16'h0000, o_tx_byte=8'h00, o_hit=0, o_busy=0, no strobes.
- Table {0x58,0x2C}, both enabled; address 0x2C write, bytes 0x12,0x34,0xAA,0xBB -> o_dev_sel=1; o_wr_en at 0x1234 data 0xAA, then 0x1235 data 0xBB; pointer ends at 0x1236.
- Write pointer 0x00,0x10, repeated start, read 3 bytes, ack data 0x5A/0x5B/0x5C -> o_rd_req at 0x0010/0x0011/0x0012; o_tx_byte follows; pointer ends at 0x0013.
- Read with i_rd_ack withheld -> after 15 cycles o_tx_byte=8'hFF, o_rd_tmo=1; next i_start clears o_rd_tmo.
- Write to pointer 0xFFFF, two data bytes -> strobes at 0xFFFF then 0x0000. ADDR_BYTES=1: pointer 0xFF wraps to 0x00.
- Address 0x2C with i_dev_en=2'b01 -> o_hit=0, no strobes. Reset asserted mid-WDATA -> no o_wr_en, all outputs 0.

Source files
------------

// File: rtl/i2c_slave_regif_mc.sv
`default_nettype none
// ============================================================================
// i2c_slave_regif_mc : I2C slave register front end (address decode, pointer,
//                      write strobes, read prefetch with timeout)   Rev 1.0
// ============================================================================
module i2c_slave_regif_mc #(
    parameter int NUM_DEV    = 2,
    parameter int ADDR_BYTES = 2,
    parameter int RD_TMO     = 15
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic                      i_addr_vld,
    input  logic [6:0]                i_dev_addr,
    input  logic                      i_rw,
    input  logic                      i_byte_vld,
    input  logic [7:0]                i_byte,
    input  logic [7*NUM_DEV-1:0]      i_dev_tbl,
    input  logic [NUM_DEV-1:0]        i_dev_en,
    output logic                      o_hit,
    output logic [1:0]                o_dev_sel,
    output logic [8*ADDR_BYTES-1:0]   o_reg_addr,
    output logic                      o_wr_en,
    output logic [7:0]                o_wr_data,
    output logic                      o_rd_req,
    input  logic [7:0]                i_rd_data,
    input  logic                      i_rd_ack,
    output logic [7:0]                o_tx_byte,
    output logic                      o_rd_tmo,
    output logic                      o_busy
);

    localparam int PW = 8 * ADDR_BYTES;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PTR    = 3'd1,
        WDATA  = 3'd2,
        RDATA  = 3'd3,
        IGNORE = 3'd4
    } state_t;

    state_t       state, state_nx;
    logic         byte_vld_q, byte_pe;
    logic [7:0]   byte_q;
    logic         hit_any;
    logic [1:0]   hit_idx;
    logic         pe_ok, ptr_last;
    logic         do_shift, do_wr, do_rd_adv, enter_rd;
    logic [1:0]   ptr_cnt;
    logic [7:0]   tmo_cnt;
    logic         need_req, waiting, inc_pend;

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_vld_q <= 1'b0;
            byte_pe    <= 1'b0;
            byte_q     <= 8'h00;
        end else begin
            byte_vld_q <= i_byte_vld;
            byte_pe    <= i_byte_vld & ~byte_vld_q;
            if (i_byte_vld & ~byte_vld_q)
                byte_q <= i_byte;
        end
    end

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = 2'd0;
        for (int k = NUM_DEV - 1; k >= 0; k--) begin
            if (i_dev_en[k] && (i_dev_tbl[7*k +: 7] == i_dev_addr)) begin
                hit_any = 1'b1;
                hit_idx = 2'(k);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        do_shift  = 1'b0;
        do_wr     = 1'b0;
        do_rd_adv = 1'b0;
        enter_rd  = 1'b0;
        pe_ok     = byte_pe & ~i_start;
        ptr_last  = (ptr_cnt == 2'(ADDR_BYTES - 1));
        case (state)
            IDLE: begin
                if (i_addr_vld) begin
                    if (hit_any) begin
                        state_nx = i_rw ? RDATA : PTR;
                        enter_rd = i_rw;
                    end else begin
                        state_nx = IGNORE;
                    end
                end
            end
            PTR: begin
                if (pe_ok) begin
                    do_shift = 1'b1;
                    if (ptr_last)
                        state_nx = WDATA;
                end
            end
            WDATA:   do_wr     = pe_ok;
            RDATA:   do_rd_adv = pe_ok;
            default: ;
        endcase
        // A byte landing with STOP is still consumed above; START drops it.
        if (i_stop || i_start) begin
            state_nx = IDLE;
            enter_rd = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hit      <= 1'b0;
            o_dev_sel  <= 2'd0;
            o_reg_addr <= '0;
            o_wr_en    <= 1'b0;
            o_wr_data  <= 8'h00;
            o_rd_req   <= 1'b0;
            o_tx_byte  <= 8'h00;
            o_rd_tmo   <= 1'b0;
            ptr_cnt    <= 2'd0;
            tmo_cnt    <= 8'd0;
            need_req   <= 1'b0;
            waiting    <= 1'b0;
            inc_pend   <= 1'b0;
        end else begin
            o_wr_en  <= do_wr;
            o_rd_req <= 1'b0;
            inc_pend <= do_wr;
            if (do_wr)
                o_wr_data <= byte_q;

            if (do_shift)
                o_reg_addr <= (o_reg_addr << 8) | PW'(byte_q);
            else if (inc_pend || do_rd_adv)
                o_reg_addr <= o_reg_addr + PW'(1);

            if (i_start)
                ptr_cnt <= 2'd0;
            else if (do_shift)
                ptr_cnt <= ptr_cnt + 2'd1;

            if (i_start || i_stop) begin
                o_hit <= 1'b0;
            end else if ((state == IDLE) && i_addr_vld) begin
                o_hit     <= hit_any;
                o_dev_sel <= hit_idx;
            end

            if (i_start)
                o_rd_tmo <= 1'b0;

            // Read prefetch: request one cycle after the pointer settles, then
            // wait for ack or timeout; anything arriving outside the window is dropped.
            if (i_start || i_stop) begin
                need_req <= 1'b0;
                waiting  <= 1'b0;
            end else if (enter_rd) begin
                need_req <= 1'b1;
            end else if (do_rd_adv) begin
                need_req <= 1'b1;
                waiting  <= 1'b0;
            end else if (need_req) begin
                need_req <= 1'b0;
                o_rd_req <= 1'b1;
                waiting  <= 1'b1;
                tmo_cnt  <= 8'd0;
            end else if (waiting) begin
                if (i_rd_ack) begin
                    o_tx_byte <= i_rd_data;
                    waiting   <= 1'b0;
                end else if (tmo_cnt == 8'(RD_TMO - 1)) begin
                    o_tx_byte <= 8'hFF;
                    o_rd_tmo  <= 1'b1;
                    waiting   <= 1'b0;
                end else begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
